// File: rtl/vga_board_renderer.sv
`timescale 1ns/1ps
// Purpose: VGA timing generator plus Tetris-well renderer (border, active piece, fallen cells, inferno blink).
// Latency: every output is registered one pixel tick after the counter values it describes.
// Backpressure: none; the display is free-running and inputs are sampled on every pixel tick.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cur_piece             active piece code (0 EMPTY, 1 I, 2 O, 3 T, 4 S, 5 Z, 6 J, 7 L)
//   cur_blk_1..cur_blk_4  linear cell indices of the active piece's four blocks
//   fallen_pieces         occupancy bitmap, bit = row*BLOCKS_WIDE + col
//   sw_inferno, pause     inferno colour/blink mode, blink-phase freeze
//   rgb, hsync, vsync, de VGA pin drivers (registered, mutually aligned)
//   frame_start           one-clk pulse when pixel (0,0) is presented
module vga_board_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_POL     = 0,
    parameter int PIX_DIV      = 4,
    parameter int BOARD_X      = 220,
    parameter int BOARD_Y      = 40,
    parameter int BLOCK_SIZE   = 20,
    parameter int BLOCKS_WIDE  = 10,
    parameter int BLOCKS_HIGH  = 20,
    parameter int POS_W        = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [2:0]                         cur_piece,
    input  logic [POS_W-1:0]                   cur_blk_1,
    input  logic [POS_W-1:0]                   cur_blk_2,
    input  logic [POS_W-1:0]                   cur_blk_3,
    input  logic [POS_W-1:0]                   cur_blk_4,
    input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces,
    input  logic                               sw_inferno,
    input  logic                               pause,
    output logic [11:0]                        rgb,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               de,
    output logic                               frame_start
);

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W    = $clog2(H_TOT);
    localparam int V_W    = $clog2(V_TOT);
    localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int N      = BLOCKS_WIDE * BLOCKS_HIGH;
    localparam int W_PIX  = BLOCKS_WIDE * BLOCK_SIZE;
    localparam int H_PIX  = BLOCKS_HIGH * BLOCK_SIZE;
    localparam int SUB_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int COL_W  = $clog2(BLOCKS_WIDE + 1);
    localparam int IDX_W  = $clog2(N + BLOCKS_WIDE + 1);
    localparam int CMP_W  = (IDX_W > POS_W) ? IDX_W : POS_W;
    localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Border ring bounds; a board touching the screen edge has no ring on that side.
    localparam int X_LO   = (BOARD_X > 0) ? BOARD_X - 1 : 0;
    localparam int Y_LO   = (BOARD_Y > 0) ? BOARD_Y - 1 : 0;

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    localparam logic [2:0] P_EMPTY = 3'd0;
    localparam logic [2:0] P_I     = 3'd1;
    localparam logic [2:0] P_O     = 3'd2;
    localparam logic [2:0] P_T     = 3'd3;
    localparam logic [2:0] P_S     = 3'd4;
    localparam logic [2:0] P_Z     = 3'd5;
    localparam logic [2:0] P_J     = 3'd6;

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_GRAY   = 12'h888;
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_PINK   = 12'hF6B;
    localparam logic [11:0] C_CYAN   = 12'h0FF;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_PURPLE = 12'h90F;
    localparam logic [11:0] C_GREEN  = 12'h0F0;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_BLUE   = 12'h00F;
    localparam logic [11:0] C_ORANGE = 12'hF80;

    function automatic logic [11:0] piece_colour(input logic [2:0] code);
        logic [11:0] c;
        case (code)
            P_EMPTY: c = C_GRAY;
            P_I:     c = C_CYAN;
            P_O:     c = C_YELLOW;
            P_T:     c = C_PURPLE;
            P_S:     c = C_GREEN;
            P_Z:     c = C_RED;
            P_J:     c = C_BLUE;
            default: c = C_ORANGE;
        endcase
        return c;
    endfunction

    // Indices at or beyond the cell count never match, whatever the grid position.
    function automatic logic blk_hit(input logic [POS_W-1:0] b, input logic [IDX_W-1:0] i);
        return (CMP_W'(b) < CMP_W'(N)) && (CMP_W'(b) == CMP_W'(i));
    endfunction

    // ---------------------------------------------------------------- pixel tick
    logic [DIV_W-1:0] div;
    logic             tick;

    assign tick = (div == DIV_W'(PIX_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // ---------------------------------------------------------------- raster counters
    logic [H_W-1:0] h, h_nxt;
    logic [V_W-1:0] v, v_nxt;
    logic           h_last, v_last;
    logic [31:0]    hx, vx, hx_nxt, vx_nxt;

    assign h_last = (h == H_W'(H_TOT - 1));
    assign v_last = (v == V_W'(V_TOT - 1));

    always_comb begin
        h_nxt = h + H_W'(1);
        v_nxt = v;
        if (h_last) begin
            h_nxt = '0;
            v_nxt = v_last ? '0 : v + V_W'(1);
        end
    end

    assign hx     = 32'(h);
    assign vx     = 32'(v);
    assign hx_nxt = 32'(h_nxt);
    assign vx_nxt = 32'(v_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            h <= h_nxt;
            v <= v_nxt;
        end
    end

    // ---------------------------------------------------------------- cell counters
    // Counters are loaded with the values for the pixel about to be addressed, so
    // they always describe the current (h, v). They saturate past the grid's far
    // edge; the region test below masks anything outside the grid anyway.
    logic [SUB_W-1:0] sub_x, sub_y;
    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] row_base;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_x <= '0;
            col   <= '0;
        end else if (tick) begin
            if (hx_nxt == BOARD_X) begin
                sub_x <= '0;
                col   <= '0;
            end else if (sub_x == SUB_W'(BLOCK_SIZE - 1)) begin
                sub_x <= '0;
                if (col != COL_W'(BLOCKS_WIDE)) begin
                    col <= col + COL_W'(1);
                end
            end else begin
                sub_x <= sub_x + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_y    <= '0;
            row_base <= '0;
        end else if (tick && h_last) begin
            if (vx_nxt == BOARD_Y) begin
                sub_y    <= '0;
                row_base <= '0;
            end else if (sub_y == SUB_W'(BLOCK_SIZE - 1)) begin
                sub_y <= '0;
                if (row_base != IDX_W'(N)) begin
                    row_base <= row_base + IDX_W'(BLOCKS_WIDE);
                end
            end else begin
                sub_y <= sub_y + SUB_W'(1);
            end
        end
    end

    assign idx = row_base + IDX_W'(col);

    // ---------------------------------------------------------------- pixel colour
    logic        pix_de, hs_act, vs_act, in_grid, in_ring, act_hit, fall_bit;
    logic        blink_phase;
    logic [11:0] pix_rgb;

    always_comb begin
        fall_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                fall_bit = fallen_pieces[i];
            end
        end
    end

    always_comb begin
        pix_de  = (hx < H_ACTIVE) && (vx < V_ACTIVE);
        hs_act  = (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
        vs_act  = (vx >= V_ACTIVE + V_FP) && (vx < V_ACTIVE + V_FP + V_SYNC);
        in_grid = (hx >= BOARD_X) && (hx < BOARD_X + W_PIX) &&
                  (vx >= BOARD_Y) && (vx < BOARD_Y + H_PIX);
        in_ring = !in_grid &&
                  (hx >= X_LO) && (hx <= BOARD_X + W_PIX) &&
                  (vx >= Y_LO) && (vx <= BOARD_Y + H_PIX);
        act_hit = blk_hit(cur_blk_1, idx) || blk_hit(cur_blk_2, idx) ||
                  blk_hit(cur_blk_3, idx) || blk_hit(cur_blk_4, idx);

        pix_rgb = C_BLACK;
        if (!pix_de) begin
            pix_rgb = C_BLACK;
        end else if (in_ring) begin
            pix_rgb = piece_colour(cur_piece);
        end else if (in_grid) begin
            if (act_hit) begin
                pix_rgb = (sw_inferno && blink_phase) ? C_BLACK : piece_colour(cur_piece);
            end else if (fall_bit) begin
                pix_rgb = sw_inferno ? C_PINK : C_WHITE;
            end else begin
                pix_rgb = sw_inferno ? C_BLACK : C_GRAY;
            end
        end
    end

    // ---------------------------------------------------------------- output registers
    logic at_origin;

    assign at_origin = (h == '0) && (v == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb         <= '0;
            de          <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            frame_start <= 1'b0;
        end else if (tick) begin
            rgb         <= pix_rgb;
            de          <= pix_de;
            hsync       <= hs_act ? SYNC_ON : SYNC_OFF;
            vsync       <= vs_act ? SYNC_ON : SYNC_OFF;
            frame_start <= at_origin;
        end else begin
            frame_start <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- blink
    // Phase advances when the origin pixel is issued; the origin is outside the
    // grid, so every grid pixel of a frame sees one consistent phase.
    logic [FC_W-1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick && at_origin && !pause) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_board_renderer.sv
`timescale 1ns/1ps
// Purpose: randomized self-checking bench for vga_board_renderer on a small raster.
// Latency: expects each output one pixel tick after the pixel it describes.
// Backpressure: none; the bench follows the free-running raster.
module tb_vga_board_renderer;

    localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int PIX_DIV = 2;
    localparam int BX = 8, BY = 3, BS = 3, BW = 6, BH = 7;
    localparam int POS_W = 6;
    localparam int BF = 2;
    localparam int H_TOT = HA + HFP + HS + HBP;
    localparam int V_TOT = VA + VFP + VS + VBP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int N = BW * BH;
    localparam int WP = BW * BS;
    localparam int HP = BH * BS;

    logic             clk;
    logic             rst_n;
    logic [2:0]       cur_piece;
    logic [POS_W-1:0] cur_blk_1, cur_blk_2, cur_blk_3, cur_blk_4;
    logic [N-1:0]     fallen_pieces;
    logic             sw_inferno;
    logic             pause;
    logic [11:0]      rgb;
    logic             hsync, vsync, de, frame_start;

    vga_board_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .PIX_DIV(PIX_DIV),
        .BOARD_X(BX), .BOARD_Y(BY), .BLOCK_SIZE(BS),
        .BLOCKS_WIDE(BW), .BLOCKS_HIGH(BH), .POS_W(POS_W),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cur_piece(cur_piece),
        .cur_blk_1(cur_blk_1), .cur_blk_2(cur_blk_2),
        .cur_blk_3(cur_blk_3), .cur_blk_4(cur_blk_4),
        .fallen_pieces(fallen_pieces), .sw_inferno(sw_inferno), .pause(pause),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
            if (errors >= 40) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    function automatic logic [11:0] pc(input logic [2:0] code);
        case (code)
            3'd0: return 12'h888;
            3'd1: return 12'h0FF;
            3'd2: return 12'hFF0;
            3'd3: return 12'h90F;
            3'd4: return 12'h0F0;
            3'd5: return 12'hF00;
            3'd6: return 12'h00F;
            default: return 12'hF80;
        endcase
    endfunction

    // Reference state: pixel number presented since reset, unpaused frame starts.
    int p;
    int nfs;
    int last_x, last_y;
    int last_fs_cyc;
    int fr;

    // Expected {rgb, hsync, vsync, de, frame_start} for raster pixel number pix.
    function automatic logic [15:0] model(input int pix);
        int x, y, idx;
        logic ph, d, hs, vs, fs, g, ring, hit;
        logic [11:0] c;
        x    = pix % H_TOT;
        y    = (pix / H_TOT) % V_TOT;
        ph   = ((nfs / BF) % 2) == 1;
        d    = (x < HA) && (y < VA);
        hs   = !((x >= HA + HFP) && (x < HA + HFP + HS));
        vs   = !((y >= VA + VFP) && (y < VA + VFP + VS));
        fs   = (x == 0) && (y == 0);
        g    = (x >= BX) && (x < BX + WP) && (y >= BY) && (y < BY + HP);
        ring = !g && (x >= BX - 1) && (x <= BX + WP) && (y >= BY - 1) && (y <= BY + HP);
        c    = 12'h000;
        if (d && ring) begin
            c = pc(cur_piece);
        end else if (d && g) begin
            idx = ((y - BY) / BS) * BW + (x - BX) / BS;
            hit = (int'(cur_blk_1) == idx) || (int'(cur_blk_2) == idx) ||
                  (int'(cur_blk_3) == idx) || (int'(cur_blk_4) == idx);
            if (hit)                     c = (sw_inferno && ph) ? 12'h000 : pc(cur_piece);
            else if (fallen_pieces[idx]) c = sw_inferno ? 12'hF6B : 12'hFFF;
            else                         c = sw_inferno ? 12'h000 : 12'h888;
        end
        return {c, hs, vs, d, fs};
    endfunction

    task automatic check_pixel();
        logic [15:0] exp;
        last_x = p % H_TOT;
        last_y = (p / H_TOT) % V_TOT;
        exp = model(p);
        check_val($sformatf("pix x%0d y%0d", last_x, last_y),
                  {16'h0, rgb, hsync, vsync, de, frame_start}, {16'h0, exp});
        if (last_x == 0 && last_y == 0) begin
            if (last_fs_cyc >= 0) check_val("frame_period", cyc - last_fs_cyc, FRAME * PIX_DIV);
            last_fs_cyc = cyc;
            if (!pause) nfs++;
        end
        p++;
    endtask

    task automatic step_pixel();
        for (int k = 0; k < PIX_DIV - 1; k++) begin
            @(posedge clk); #1;
            check_val("fs_gap", {31'h0, frame_start}, 32'h0);
        end
        @(posedge clk); #1;
        check_pixel();
    endtask

    // After reset release, find the first tick (it carries frame_start) and check it.
    task automatic sync_start();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 4 * PIX_DIV && !found; k++) begin
            @(posedge clk); #1;
            if (frame_start) found = 1'b1;
        end
        check_val("first_fs", {31'h0, found}, 32'h1);
        p = 0;
        nfs = 0;
        last_fs_cyc = -1;
        check_pixel();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_rgb"}, {20'h0, rgb}, 32'h0);
        check_val({tag, "_de"}, {31'h0, de}, 32'h0);
        check_val({tag, "_hs"}, {31'h0, hsync}, 32'h1);
        check_val({tag, "_vs"}, {31'h0, vsync}, 32'h1);
        check_val({tag, "_fs"}, {31'h0, frame_start}, 32'h0);
    endtask

    task automatic apply_frame_inputs(input int f);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (f == 0) begin
            // T piece at row 1 col 3, fallen neighbour at col 4, rest out of range.
            cur_piece     = 3'd3;
            cur_blk_1     = POS_W'(9);
            cur_blk_2     = POS_W'(63);
            cur_blk_3     = POS_W'(N);
            cur_blk_4     = POS_W'(63);
            fallen_pieces = '0;
            fallen_pieces[10] = 1'b1;
            sw_inferno    = 1'b0;
        end else if (f == 1) begin
            cur_piece     = 3'($urandom_range(1, 7));
            cur_blk_1     = POS_W'($urandom_range(N, 63));
            cur_blk_2     = POS_W'($urandom_range(N, 63));
            cur_blk_3     = POS_W'($urandom_range(N, 63));
            cur_blk_4     = POS_W'($urandom_range(N, 63));
            fallen_pieces = r[N-1:0];
            sw_inferno    = 1'b0;
        end else begin
            cur_piece     = 3'($urandom_range(0, 7));
            cur_blk_1     = POS_W'($urandom_range(0, N - 1));
            cur_blk_2     = POS_W'($urandom_range(0, 63));
            cur_blk_3     = POS_W'($urandom_range(0, 63));
            cur_blk_4     = ($urandom_range(0, 3) == 0) ? cur_blk_1 : POS_W'($urandom_range(0, 63));
            fallen_pieces = r[N-1:0];
            sw_inferno    = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic did_rst;
        logic [63:0] r;
        did_rst = 1'b0;
        fr = 0;
        pause = 1'b0;
        rst_n = 1'b0;
        apply_frame_inputs(0);
        repeat (5) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        sync_start();

        while (fr < 14) begin
            step_pixel();
            if (last_x == 0 && last_y == 0) begin
                fr++;
                apply_frame_inputs(fr);
            end
            if (last_x == 0 && last_y == 10) begin
                if (fr == 4) pause = 1'b1;
                if (fr == 9) pause = 1'b0;
                if (fr >= 2) begin
                    r = {$urandom(), $urandom()};
                    fallen_pieces = r[N-1:0];
                    cur_blk_2 = POS_W'($urandom_range(0, 63));
                end
            end
            if (fr == 11 && !did_rst && last_x == 5 && last_y == 20) begin
                did_rst = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                check_reset("midrst");
                repeat (3) @(posedge clk);
                #1;
                check_reset("midrst_hold");
                @(negedge clk);
                rst_n = 1'b1;
                sync_start();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
